// File: rtl/dmac_pkg.sv
// Shared AHB encodings, sequencer state type and burst-size decode for the
// DMAC channel controllers.
package dmac_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_REQ,
      ST_RD,
      ST_WR,
      ST_DONE,
      ST_ERR
   } state_t;

   // Unused BS codes fall back to single-beat transfers.
   function automatic logic [4:0] bs_to_beats(input logic [2:0] bs);
      logic [4:0] beats;
      case (bs)
         3'd1:    beats = 5'd4;
         3'd2:    beats = 5'd8;
         3'd3:    beats = 5'd16;
         default: beats = 5'd1;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/dmac_beat_tracker.sv
// Counts address phases issued and data beats completed within one burst;
// flags when the current address/beat is the last one of the burst.
module dmac_beat_tracker #(
   parameter int IDXW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            addr_inc,
   input  logic            data_inc,
   input  logic [IDXW-1:0] last_idx,
   output logic            addr_last,
   output logic            data_last
);

   logic [IDXW-1:0] issued;
   logic [IDXW-1:0] completed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued    <= '0;
         completed <= '0;
      end else if (clear) begin
         issued    <= '0;
         completed <= '0;
      end else begin
         if (addr_inc) issued    <= issued + IDXW'(1);
         if (data_inc) completed <= completed + IDXW'(1);
      end
   end

   assign addr_last = (issued == last_idx);
   assign data_last = (completed == last_idx);

endmodule

// File: rtl/dmac_ch0_ctrl.sv
// Channel-0 DMA sequencer: read burst into the local buffer, write it back
// out, repeat until the programmed size is exhausted or the bus errors.
module dmac_ch0_ctrl
   import dmac_pkg::*;
#(
   parameter int BUF_DEPTH = 16,
   parameter int IDXW      = 4
) (
   input  logic        r_HCLK,
   input  logic        r_HRESETn,
   input  logic        CHANNEL_enable,
   input  logic [11:0] TS,
   input  logic [2:0]  BS,
   input  logic        sync_grant,
   input  logic        m_HREADY,
   input  logic [1:0]  m_HRESP,
   output logic        m_HBUSREQ,
   output logic [1:0]  m_HTRANS,
   output logic        m_HWRITE,
   output logic [2:0]  m_HSIZE,
   output logic        load_DMAC_C0_Addr,
   output logic        src_addr_inc,
   output logic        dest_addr_inc,
   output logic        src_burst_zero_flag,
   output logic        dest_burst_zero_flag,
   output logic        buffer_zero_flag,
   output logic        buffer_idx_inc,
   output logic        buffer_wr_en,
   output logic        TransferSize_dec_flag,
   output logic        CHANNEL_dis_flag,
   output logic        set_DMACINTR_status,
   output logic        err_flag,
   output logic        busy
);

   localparam logic [9:0] DEPTH_WORDS = 10'(BUF_DEPTH);

   state_t          state;
   logic [9:0]      ts_words;
   logic [9:0]      dec_words;
   logic [9:0]      burst_words;
   logic [9:0]      rem_words;
   logic [IDXW-1:0] last_idx;
   logic            data_phase;
   logic            bus_err;
   logic            addr_accept;
   logic            beat_done;
   logic            start_burst;
   logic            burst_clear;
   logic            addr_last;
   logic            data_last;
   logic            ts_lsb_unused;

   assign ts_words      = TS[11:2];
   assign ts_lsb_unused = ^TS[1:0];
   assign m_HSIZE       = HSIZE_WORD;

   always_comb begin
      dec_words = {5'd0, bs_to_beats(BS)};
      if (dec_words > DEPTH_WORDS) dec_words = DEPTH_WORDS;
      burst_words = (dec_words < ts_words) ? dec_words : ts_words;
   end

   // Beat strobes are qualified by HREADY in the same cycle so the register
   // bank can step addresses in time for the next pipelined address phase.
   assign bus_err     = data_phase && (m_HRESP == HRESP_ERROR);
   assign addr_accept = (m_HTRANS != HTRANS_IDLE) && m_HREADY && !bus_err;
   assign beat_done   = data_phase && m_HREADY && !bus_err;

   assign src_addr_inc          = addr_accept && (state == ST_RD);
   assign dest_addr_inc         = addr_accept && (state == ST_WR);
   assign buffer_wr_en          = beat_done && (state == ST_RD);
   assign buffer_idx_inc        = beat_done;
   assign TransferSize_dec_flag = beat_done && (state == ST_WR);

   assign start_burst = (state == ST_REQ) && CHANNEL_enable && sync_grant;
   assign burst_clear = start_burst || ((state == ST_RD) && beat_done && data_last);

   dmac_beat_tracker #(.IDXW(IDXW)) u_tracker (
      .clk       (r_HCLK),
      .rst_n     (r_HRESETn),
      .clear     (burst_clear),
      .addr_inc  (addr_accept),
      .data_inc  (beat_done),
      .last_idx  (last_idx),
      .addr_last (addr_last),
      .data_last (data_last)
   );

   always_ff @(posedge r_HCLK or negedge r_HRESETn) begin
      if (!r_HRESETn) begin
         state                <= ST_IDLE;
         m_HBUSREQ            <= 1'b0;
         m_HTRANS             <= HTRANS_IDLE;
         m_HWRITE             <= 1'b0;
         load_DMAC_C0_Addr    <= 1'b0;
         src_burst_zero_flag  <= 1'b0;
         dest_burst_zero_flag <= 1'b0;
         buffer_zero_flag     <= 1'b0;
         CHANNEL_dis_flag     <= 1'b0;
         set_DMACINTR_status  <= 1'b0;
         err_flag             <= 1'b0;
         busy                 <= 1'b0;
         data_phase           <= 1'b0;
         last_idx             <= '0;
         rem_words            <= '0;
      end else begin
         load_DMAC_C0_Addr    <= 1'b0;
         src_burst_zero_flag  <= 1'b0;
         dest_burst_zero_flag <= 1'b0;
         buffer_zero_flag     <= 1'b0;
         CHANNEL_dis_flag     <= 1'b0;
         set_DMACINTR_status  <= 1'b0;
         err_flag             <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (CHANNEL_enable) begin
                  busy <= 1'b1;
                  if (ts_words != 10'd0) begin
                     state             <= ST_LOAD;
                     load_DMAC_C0_Addr <= 1'b1;
                  end else begin
                     state               <= ST_DONE;
                     CHANNEL_dis_flag    <= 1'b1;
                     set_DMACINTR_status <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               state     <= ST_REQ;
               m_HBUSREQ <= 1'b1;
            end
            ST_REQ: begin
               if (!CHANNEL_enable) begin
                  state     <= ST_IDLE;
                  m_HBUSREQ <= 1'b0;
                  busy      <= 1'b0;
               end else if (sync_grant) begin
                  state               <= ST_RD;
                  last_idx            <= IDXW'(burst_words - 10'd1);
                  rem_words           <= ts_words - burst_words;
                  src_burst_zero_flag <= 1'b1;
                  buffer_zero_flag    <= 1'b1;
                  m_HTRANS            <= HTRANS_NONSEQ;
                  m_HWRITE            <= 1'b0;
                  data_phase          <= 1'b0;
               end
            end
            ST_RD, ST_WR: begin
               if (bus_err) begin
                  state               <= ST_ERR;
                  m_HTRANS            <= HTRANS_IDLE;
                  m_HBUSREQ           <= 1'b0;
                  m_HWRITE            <= 1'b0;
                  data_phase          <= 1'b0;
                  CHANNEL_dis_flag    <= 1'b1;
                  set_DMACINTR_status <= 1'b1;
                  err_flag            <= 1'b1;
               end else begin
                  if (addr_accept) m_HTRANS <= addr_last ? HTRANS_IDLE : HTRANS_SEQ;
                  if (m_HREADY) data_phase <= addr_accept;
                  if (beat_done && data_last) begin
                     data_phase <= 1'b0;
                     if (state == ST_RD) begin
                        state                <= ST_WR;
                        m_HWRITE             <= 1'b1;
                        m_HTRANS             <= HTRANS_NONSEQ;
                        buffer_zero_flag     <= 1'b1;
                        dest_burst_zero_flag <= 1'b1;
                     end else if (rem_words == 10'd0) begin
                        state               <= ST_DONE;
                        m_HBUSREQ           <= 1'b0;
                        m_HWRITE            <= 1'b0;
                        CHANNEL_dis_flag    <= 1'b1;
                        set_DMACINTR_status <= 1'b1;
                     end else begin
                        state    <= ST_REQ;
                        m_HWRITE <= 1'b0;
                     end
                  end
               end
            end
            ST_DONE, ST_ERR: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
